// File: rtl/riscv_pkg.sv
// Shared load/store definitions: access-size encodings, memory-stage states and lane helpers.
package riscv_pkg;

  typedef enum logic [2:0] {
    LS_B  = 3'b000,
    LS_H  = 3'b001,
    LS_W  = 3'b010,
    LS_BU = 3'b100,
    LS_HU = 3'b101
  } ls_funct3_e;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} mem_state_e;

  localparam int unsigned LS_STORE_BIT = 3;

  function automatic logic funct3_ok(input logic [2:0] f3);
    case (f3)
      LS_B, LS_H, LS_W, LS_BU, LS_HU: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

  // Force the byte lane to the natural alignment of the access size.
  function automatic logic [1:0] natural_lane(input logic [2:0] f3, input logic [1:0] lane);
    case (f3[1:0])
      2'b00:   return lane;
      2'b01:   return {lane[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lane);
    return ((f3[1:0] == 2'b01) && lane[0]) || ((f3[1:0] == 2'b10) && (lane != 2'b00));
  endfunction

endpackage

// File: rtl/ls_align.sv
// Combinational lane steering: byte enables and replicated store data on the request side,
// lane extraction plus sign/zero extension on the load-return side.
module ls_align
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [1:0]      st_size,
  input  logic [1:0]      st_lane,
  input  logic [XLEN-1:0] st_data,
  output logic [3:0]      be,
  output logic [XLEN-1:0] wdata,
  input  logic [2:0]      ld_funct3,
  input  logic [1:0]      ld_lane,
  input  logic [XLEN-1:0] ld_rdata,
  output logic [XLEN-1:0] ld_val
);

  logic [XLEN-1:0] shifted;

  always_comb begin
    be    = 4'b1111;
    wdata = st_data;
    case (st_size)
      2'b00: begin
        be    = 4'b0001 << st_lane;
        wdata = {(XLEN/8){st_data[7:0]}};
      end
      2'b01: begin
        be    = 4'b0011 << st_lane;
        wdata = {(XLEN/16){st_data[15:0]}};
      end
      default: ;
    endcase
  end

  assign shifted = ld_rdata >> {ld_lane, 3'b000};

  always_comb begin
    ld_val = shifted;
    case (ld_funct3)
      LS_B:    ld_val = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      LS_BU:   ld_val = {{(XLEN-8){1'b0}}, shifted[7:0]};
      LS_H:    ld_val = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      LS_HU:   ld_val = {{(XLEN-16){1'b0}}, shifted[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: one outstanding req/gnt/rvalid access, load alignment, writeback.
// Optional MISALIGN_TRAP_EN: trap misaligned H/W accesses instead of forcing natural alignment.
module mem_access_stage
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic            ex_is_ls,
  input  logic [3:0]      ex_ls_type,
  input  logic [XLEN-1:0] ex_addr,
  input  logic [XLEN-1:0] ex_data,
  input  logic [4:0]      ex_rd,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [3:0]      dmem_be,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_gnt,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_val,
  output logic [XLEN-1:0] mem_rd_val,
  output logic            bus_err
`ifdef MISALIGN_TRAP_EN
  ,
  output logic            misalign_trap
`endif
);

  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYC - 1);

  mem_state_e      state_q;
  logic [2:0]      funct3_q;
  logic [1:0]      lane_q;
  logic            is_store_q;
  logic [4:0]      rd_q;
  logic [7:0]      cnt_q;

  logic [2:0]      ex_f3;
  logic            ex_store;
  logic [1:0]      ex_lane;
  logic            accept;
  logic [3:0]      st_be;
  logic [XLEN-1:0] st_wdata;
  logic [XLEN-1:0] ld_val;

  assign ex_f3    = ex_ls_type[2:0];
  assign ex_store = ex_ls_type[LS_STORE_BIT];
  assign accept   = ex_valid & ex_ready;

`ifdef MISALIGN_TRAP_EN
  logic ex_misalign;
  assign ex_lane     = ex_addr[1:0];
  assign ex_misalign = misaligned(ex_f3, ex_addr[1:0]);
`else
  assign ex_lane = natural_lane(ex_f3, ex_addr[1:0]);
`endif

  ls_align #(.XLEN(XLEN)) u_align (
    .st_size  (ex_f3[1:0]),
    .st_lane  (ex_lane),
    .st_data  (ex_data),
    .be       (st_be),
    .wdata    (st_wdata),
    .ld_funct3(funct3_q),
    .ld_lane  (lane_q),
    .ld_rdata (dmem_rdata),
    .ld_val   (ld_val)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      funct3_q      <= '0;
      lane_q        <= '0;
      is_store_q    <= 1'b0;
      rd_q          <= '0;
      cnt_q         <= '0;
      ex_ready      <= 1'b0;
      dmem_req      <= 1'b0;
      dmem_we       <= 1'b0;
      dmem_be       <= '0;
      dmem_addr     <= '0;
      dmem_wdata    <= '0;
      wb_valid      <= 1'b0;
      wb_rd         <= '0;
      wb_val        <= '0;
      mem_rd_val    <= '0;
      bus_err       <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      misalign_trap <= 1'b0;
`endif
    end else begin
      bus_err <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      misalign_trap <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          ex_ready <= 1'b1;
          if (accept) begin
            ex_ready   <= 1'b0;
            cnt_q      <= '0;
            rd_q       <= ex_rd;
            funct3_q   <= ex_f3;
            lane_q     <= ex_lane;
            is_store_q <= ex_store;
            if (!ex_is_ls) begin
              state_q  <= RESP;
              wb_valid <= 1'b1;
              wb_rd    <= ex_rd;
              wb_val   <= ex_data;
            end else if (!funct3_ok(ex_f3)) begin
              state_q  <= RESP;
              wb_valid <= 1'b1;
              wb_rd    <= ex_store ? 5'd0 : ex_rd;
              wb_val   <= '0;
              bus_err  <= 1'b1;
`ifdef MISALIGN_TRAP_EN
            end else if (ex_misalign) begin
              state_q       <= RESP;
              wb_valid      <= 1'b1;
              wb_rd         <= '0;
              wb_val        <= '0;
              misalign_trap <= 1'b1;
`endif
            end else begin
              state_q    <= REQ;
              dmem_req   <= 1'b1;
              dmem_we    <= ex_store;
              dmem_be    <= st_be;
              dmem_addr  <= {ex_addr[XLEN-1:2], 2'b00};
              dmem_wdata <= ex_store ? st_wdata : '0;
            end
          end
        end
        REQ: begin
          if (dmem_gnt) begin
            state_q  <= WAIT;
            dmem_req <= 1'b0;
            cnt_q    <= '0;
          end else if (cnt_q == TimeoutLast) begin
            state_q  <= RESP;
            dmem_req <= 1'b0;
            wb_valid <= 1'b1;
            wb_rd    <= is_store_q ? 5'd0 : rd_q;
            wb_val   <= '0;
            bus_err  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        WAIT: begin
          // rvalid is only looked at here, so a response coincident with gnt is dropped.
          if (dmem_rvalid) begin
            state_q  <= RESP;
            wb_valid <= 1'b1;
            wb_rd    <= is_store_q ? 5'd0 : rd_q;
            wb_val   <= (is_store_q || (rd_q == 5'd0)) ? '0 : ld_val;
          end else if (cnt_q == TimeoutLast) begin
            state_q  <= RESP;
            wb_valid <= 1'b1;
            wb_rd    <= is_store_q ? 5'd0 : rd_q;
            wb_val   <= '0;
            bus_err  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        RESP: begin
          if (wb_ready) begin
            state_q    <= IDLE;
            wb_valid   <= 1'b0;
            mem_rd_val <= wb_val;
            ex_ready   <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: vector table of single accesses plus hand-written
// sequences for wb back-pressure, bus timeout, gnt/rvalid overlap and mid-access reset.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid = 1'b0;
  logic        ex_ready;
  logic        ex_is_ls = 1'b0;
  logic [3:0]  ex_ls_type = '0;
  logic [31:0] ex_addr = '0;
  logic [31:0] ex_data = '0;
  logic [4:0]  ex_rd = '0;
  logic        dmem_req;
  logic        dmem_we;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt = 1'b0;
  logic        dmem_rvalid = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic        wb_valid;
  logic        wb_ready = 1'b0;
  logic [4:0]  wb_rd;
  logic [31:0] wb_val;
  logic [31:0] mem_rd_val;
  logic        bus_err;

  mem_access_stage #(.XLEN(32), .TIMEOUT_CYC(255)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ex_valid   (ex_valid),
    .ex_ready   (ex_ready),
    .ex_is_ls   (ex_is_ls),
    .ex_ls_type (ex_ls_type),
    .ex_addr    (ex_addr),
    .ex_data    (ex_data),
    .ex_rd      (ex_rd),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_be    (dmem_be),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_gnt   (dmem_gnt),
    .dmem_rvalid(dmem_rvalid),
    .dmem_rdata (dmem_rdata),
    .wb_valid   (wb_valid),
    .wb_ready   (wb_ready),
    .wb_rd      (wb_rd),
    .wb_val     (wb_val),
    .mem_rd_val (mem_rd_val),
    .bus_err    (bus_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        is_ls;
    logic [3:0]  ls_type;
    logic [31:0] addr;
    logic [31:0] data;
    logic [4:0]  rd;
    logic [31:0] rdata;
    logic        bus;
    logic        err;
    logic        we;
    logic [3:0]  be;
    logic [31:0] daddr;
    logic [31:0] wdata;
    logic [4:0]  wrd;
    logic [31:0] wval;
  } vec_t;

  vec_t vecs[13];

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!ex_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("%s ex_ready", tag), 32'(ex_ready), 32'd1);
  endtask

  task automatic issue(input logic is_ls, input logic [3:0] ty, input logic [31:0] addr,
                       input logic [31:0] data, input logic [4:0] rd);
    ex_valid   = 1'b1;
    ex_is_ls   = is_ls;
    ex_ls_type = ty;
    ex_addr    = addr;
    ex_data    = data;
    ex_rd      = rd;
    @(negedge clk);
    ex_valid = 1'b0;
  endtask

  task automatic retire();
    wb_ready = 1'b1;
    @(negedge clk);
    wb_ready = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("v%0d", idx);
    wait_ready(tag);
    issue(v.is_ls, v.ls_type, v.addr, v.data, v.rd);
    if (v.bus) begin
      check($sformatf("%s req", tag), 32'(dmem_req), 32'd1);
      check($sformatf("%s we", tag), 32'(dmem_we), 32'(v.we));
      check($sformatf("%s be", tag), 32'(dmem_be), 32'(v.be));
      check($sformatf("%s addr", tag), dmem_addr, v.daddr);
      if (v.we) check($sformatf("%s wdata", tag), dmem_wdata, v.wdata);
      dmem_gnt = 1'b1;
      @(negedge clk);
      dmem_gnt = 1'b0;
      check($sformatf("%s req drop", tag), 32'(dmem_req), 32'd0);
      dmem_rvalid = 1'b1;
      dmem_rdata  = v.rdata;
      @(negedge clk);
      dmem_rvalid = 1'b0;
    end else begin
      check($sformatf("%s no req", tag), 32'(dmem_req), 32'd0);
    end
    check($sformatf("%s wb_valid", tag), 32'(wb_valid), 32'd1);
    check($sformatf("%s wb_rd", tag), 32'(wb_rd), 32'(v.wrd));
    check($sformatf("%s wb_val", tag), wb_val, v.wval);
    check($sformatf("%s bus_err", tag), 32'(bus_err), 32'(v.err));
    retire();
    check($sformatf("%s wb_valid clr", tag), 32'(wb_valid), 32'd0);
    check($sformatf("%s mem_rd_val", tag), mem_rd_val, v.wval);
  endtask

  initial begin
    int n;
    //          is_ls type     addr          data          rd     rdata         bus  err  we  be       daddr         wdata         wrd    wval
    vecs[0]  = '{1'b1, 4'b0010, 32'h0000_0100, 32'h0,        5'd5,  32'hDEAD_BEEF, 1, 0, 0, 4'b1111, 32'h0000_0100, 32'h0,        5'd5,  32'hDEAD_BEEF};
    vecs[1]  = '{1'b1, 4'b0000, 32'h0000_0103, 32'h0,        5'd6,  32'h80FF_0000, 1, 0, 0, 4'b1000, 32'h0000_0100, 32'h0,        5'd6,  32'hFFFF_FF80};
    vecs[2]  = '{1'b1, 4'b0100, 32'h0000_0103, 32'h0,        5'd6,  32'h80FF_0000, 1, 0, 0, 4'b1000, 32'h0000_0100, 32'h0,        5'd6,  32'h0000_0080};
    vecs[3]  = '{1'b1, 4'b1001, 32'h0000_0102, 32'h1234_ABCD, 5'd9,  32'h0,        1, 0, 1, 4'b1100, 32'h0000_0100, 32'hABCD_ABCD, 5'd0,  32'h0};
    vecs[4]  = '{1'b1, 4'b1000, 32'h0000_0201, 32'h0000_00A5, 5'd3,  32'h0,        1, 0, 1, 4'b0010, 32'h0000_0200, 32'hA5A5_A5A5, 5'd0,  32'h0};
    vecs[5]  = '{1'b1, 4'b0001, 32'h0000_0202, 32'h0,        5'd12, 32'h8001_1234, 1, 0, 0, 4'b1100, 32'h0000_0200, 32'h0,        5'd12, 32'hFFFF_8001};
    vecs[6]  = '{1'b1, 4'b0101, 32'h0000_0202, 32'h0,        5'd12, 32'h8001_1234, 1, 0, 0, 4'b1100, 32'h0000_0200, 32'h0,        5'd12, 32'h0000_8001};
    vecs[7]  = '{1'b1, 4'b0001, 32'h0000_0201, 32'h0,        5'd13, 32'h0000_F00D, 1, 0, 0, 4'b0011, 32'h0000_0200, 32'h0,        5'd13, 32'hFFFF_F00D};
    vecs[8]  = '{1'b1, 4'b0010, 32'h0000_0107, 32'h0,        5'd2,  32'h1234_5678, 1, 0, 0, 4'b1111, 32'h0000_0104, 32'h0,        5'd2,  32'h1234_5678};
    vecs[9]  = '{1'b1, 4'b0010, 32'h0000_0300, 32'h0,        5'd0,  32'hCAFE_BABE, 1, 0, 0, 4'b1111, 32'h0000_0300, 32'h0,        5'd0,  32'h0};
    vecs[10] = '{1'b1, 4'b1010, 32'h0000_0400, 32'h1122_3344, 5'd1,  32'h0,        1, 0, 1, 4'b1111, 32'h0000_0400, 32'h1122_3344, 5'd0,  32'h0};
    vecs[11] = '{1'b0, 4'b0000, 32'h0000_0000, 32'h0000_0055, 5'd7,  32'h0,        0, 0, 0, 4'b0000, 32'h0,        32'h0,        5'd7,  32'h0000_0055};
    vecs[12] = '{1'b1, 4'b0011, 32'h0000_0500, 32'h0,        5'd4,  32'h0,        0, 1, 0, 4'b0000, 32'h0,        32'h0,        5'd4,  32'h0};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst ex_ready", 32'(ex_ready), 32'd0);
    check("rst dmem_req", 32'(dmem_req), 32'd0);
    check("rst wb_valid", 32'(wb_valid), 32'd0);
    check("rst mem_rd_val", mem_rd_val, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post-rst ex_ready", 32'(ex_ready), 32'd1);

    // Non-LS result held under writeback back-pressure
    issue(1'b0, 4'b0000, 32'h0, 32'h0000_0055, 5'd7);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("hold%0d wb_valid", i), 32'(wb_valid), 32'd1);
      check($sformatf("hold%0d ex_ready", i), 32'(ex_ready), 32'd0);
      check($sformatf("hold%0d mem_rd_val", i), mem_rd_val, 32'd0);
      @(negedge clk);
    end
    check("hold wb_val", wb_val, 32'h55);
    check("hold wb_rd", 32'(wb_rd), 32'd7);
    retire();
    check("hold mem_rd_val", mem_rd_val, 32'h55);
    check("hold ex_ready", 32'(ex_ready), 32'd1);

    foreach (vecs[i]) run_vec(vecs[i], i);

    // gnt withheld: timeout after 255 request cycles
    wait_ready("tmo");
    issue(1'b1, 4'b0010, 32'h0000_0700, 32'h0, 5'd11);
    n = 0;
    while (dmem_req && n < 400) begin
      n++;
      @(negedge clk);
    end
    check("tmo req cycles", 32'(n), 32'd255);
    check("tmo bus_err", 32'(bus_err), 32'd1);
    check("tmo wb_valid", 32'(wb_valid), 32'd1);
    check("tmo wb_val", wb_val, 32'd0);
    @(negedge clk);
    check("tmo bus_err pulse", 32'(bus_err), 32'd0);
    retire();
    check("tmo ex_ready", 32'(ex_ready), 32'd1);
    check("tmo mem_rd_val", mem_rd_val, 32'd0);

    // rvalid coincident with gnt is ignored
    wait_ready("ovl");
    issue(1'b1, 4'b0010, 32'h0000_0600, 32'h0, 5'd10);
    dmem_gnt    = 1'b1;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h1111_1111;
    @(negedge clk);
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b0;
    check("ovl wb_valid early", 32'(wb_valid), 32'd0);
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h2222_2222;
    @(negedge clk);
    dmem_rvalid = 1'b0;
    check("ovl wb_valid", 32'(wb_valid), 32'd1);
    check("ovl wb_val", wb_val, 32'h2222_2222);
    retire();

    // Asynchronous reset while waiting for rvalid
    wait_ready("arst");
    issue(1'b1, 4'b0010, 32'h0000_0800, 32'h0, 5'd8);
    dmem_gnt = 1'b1;
    @(negedge clk);
    dmem_gnt = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst dmem_req", 32'(dmem_req), 32'd0);
    check("arst ex_ready", 32'(ex_ready), 32'd0);
    check("arst dmem_addr", dmem_addr, 32'd0);
    check("arst mem_rd_val", mem_rd_val, 32'd0);
    @(negedge clk);
    rst_n       = 1'b1;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h3333_3333;
    @(negedge clk);
    dmem_rvalid = 1'b0;
    check("arst late rvalid", 32'(wb_valid), 32'd0);
    check("arst ex_ready", 32'(ex_ready), 32'd1);
    run_vec(vecs[0], 100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
